// File: rtl/global_ofm_store_unit_if.sv
// Element stream and global BRAM write bus of global_ofm_store_unit.
// With OFM_STORE_LANE_MASK_EN defined the bus also carries the per-lane write enable wr_be_global.
interface global_ofm_store_unit_if #(
  parameter int DATA_W = 8,
  parameter int PACK   = 16
);
  logic                   in_valid;
  logic [DATA_W-1:0]      in_data;
  logic                   in_ready;
  logic                   global_busy;
  logic [31:0]            wr_addr_global;
  logic [DATA_W*PACK-1:0] wr_data_global;
  logic                   we_global;
`ifdef OFM_STORE_LANE_MASK_EN
  logic [PACK-1:0]        wr_be_global;

  // master is the store unit, slave is the fused datapath plus BRAM side
  modport master (
    input  in_valid, in_data, global_busy,
    output in_ready, wr_addr_global, wr_data_global, we_global, wr_be_global
  );
  modport slave (
    output in_valid, in_data, global_busy,
    input  in_ready, wr_addr_global, wr_data_global, we_global, wr_be_global
  );
`else
  modport master (
    input  in_valid, in_data, global_busy,
    output in_ready, wr_addr_global, wr_data_global, we_global
  );
  modport slave (
    output in_valid, in_data, global_busy,
    input  in_ready, wr_addr_global, wr_data_global, we_global
  );
`endif
endinterface

// File: rtl/global_ofm_store_unit.sv
// Packs layer-2 OFM elements into global words, buffers them and writes them to global BRAM.
// Optional feature macro: OFM_STORE_LANE_MASK_EN (per-lane write enable wr_be_global).
module global_ofm_store_unit #(
  parameter int DATA_W     = 8,
  parameter int PACK       = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_i,
  input  logic [31:0]              base_addr_OFM_i,
  input  logic [31:0]              size_OFM_i,
  output logic                     busy_o,
  output logic                     done_o,
  global_ofm_store_unit_if.master  bus
);

  localparam int WORD_W = DATA_W * PACK;
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q;
  logic              busy_q, done_q;

  logic [31:0]       base_q, base_d;
  logic [31:0]       size_q, size_d;
  logic [31:0]       elemCnt_q, elemCnt_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [WORD_W-1:0] packReg_q, packReg_d;
  logic              flushPending_q, flushPending_d;

  logic [WORD_W-1:0] fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [31:0]       wcount_q, wcount_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;

`ifdef OFM_STORE_LANE_MASK_EN
  logic [PACK-1:0]   beMem [FIFO_DEPTH];
  logic [PACK-1:0]   be_q, be_d;
  logic [PACK-1:0]   partialMask;
  logic [PACK-1:0]   pushBe;
`endif

  logic              fifoFull, fifoEmpty;
  logic              inReady, accept, startAcc;
  logic              laneLast, lastElem;
  logic              pushFull, pushFlush, push, pop;
  logic [WORD_W-1:0] filledWord, pushWord;

  assign fifoFull  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifoEmpty = (count_q == '0);
  assign inReady   = (state_q == RUN) && !fifoFull && !flushPending_q;
  assign accept    = bus.in_valid && inReady;
  assign startAcc  = start_i && (state_q == IDLE);
  assign laneLast  = (lane_q == LANE_W'(PACK - 1));
  assign lastElem  = accept && ((elemCnt_q + 32'd1) == size_q);

  // A partial last word waits one cycle in the packing register before it is pushed
  assign pushFull  = accept && laneLast;
  assign pushFlush = flushPending_q && !fifoFull;
  assign push      = pushFull || pushFlush;
  assign pop       = !fifoEmpty && !bus.global_busy;
  assign pushWord  = pushFlush ? packReg_q : filledWord;

  always_comb begin
    filledWord = packReg_q;
    filledWord[int'(lane_q)*DATA_W +: DATA_W] = bus.in_data;
  end

`ifdef OFM_STORE_LANE_MASK_EN
  // At flush time lane_q equals size mod PACK, i.e. the number of real lanes
  always_comb begin
    partialMask = '0;
    for (int k = 0; k < PACK; k++) begin
      partialMask[k] = (k < int'(lane_q));
    end
  end

  assign pushBe = pushFlush ? partialMask : '1;
`endif

  always_comb begin
    base_d         = base_q;
    size_d         = size_q;
    elemCnt_d      = elemCnt_q;
    lane_d         = lane_q;
    packReg_d      = packReg_q;
    flushPending_d = flushPending_q;
    wrPtr_d        = wrPtr_q;
    rdPtr_d        = rdPtr_q;
    count_d        = count_q + CNT_W'(push) - CNT_W'(pop);
    wcount_d       = wcount_q;
    we_d           = pop;
    addr_d         = addr_q;
    data_d         = data_q;
`ifdef OFM_STORE_LANE_MASK_EN
    be_d           = be_q;
`endif

    if (push) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end

    if (pop) begin
      rdPtr_d  = rdPtr_q + PTR_W'(1);
      addr_d   = base_q + (wcount_q << 4);
      data_d   = fifoMem[rdPtr_q];
      wcount_d = wcount_q + 32'd1;
`ifdef OFM_STORE_LANE_MASK_EN
      be_d     = beMem[rdPtr_q];
`endif
    end

    if (startAcc) begin
      base_d         = base_addr_OFM_i;
      size_d         = size_OFM_i;
      elemCnt_d      = '0;
      lane_d         = '0;
      packReg_d      = '0;
      flushPending_d = 1'b0;
      wcount_d       = '0;
    end else begin
      if (accept) begin
        elemCnt_d = elemCnt_q + 32'd1;
        if (laneLast) begin
          lane_d    = '0;
          packReg_d = '0;
        end else begin
          lane_d    = lane_q + LANE_W'(1);
          packReg_d = filledWord;
          if (lastElem) begin
            flushPending_d = 1'b1;
          end
        end
      end
      if (pushFlush) begin
        flushPending_d = 1'b0;
        packReg_d      = '0;
        lane_d         = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q         <= '0;
      size_q         <= '0;
      elemCnt_q      <= '0;
      lane_q         <= '0;
      packReg_q      <= '0;
      flushPending_q <= 1'b0;
      wrPtr_q        <= '0;
      rdPtr_q        <= '0;
      count_q        <= '0;
      wcount_q       <= '0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      data_q         <= '0;
`ifdef OFM_STORE_LANE_MASK_EN
      be_q           <= '0;
`endif
    end else begin
      base_q         <= base_d;
      size_q         <= size_d;
      elemCnt_q      <= elemCnt_d;
      lane_q         <= lane_d;
      packReg_q      <= packReg_d;
      flushPending_q <= flushPending_d;
      wrPtr_q        <= wrPtr_d;
      rdPtr_q        <= rdPtr_d;
      count_q        <= count_d;
      wcount_q       <= wcount_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
`ifdef OFM_STORE_LANE_MASK_EN
      be_q           <= be_d;
`endif
    end
  end

  // Storage needs no reset: the occupancy counter decides what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr_q] <= pushWord;
`ifdef OFM_STORE_LANE_MASK_EN
      beMem[wrPtr_q]   <= pushBe;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            if (size_OFM_i == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if ((lastElem && laneLast) || pushFlush) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifoEmpty && !flushPending_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready       = inReady;
  assign bus.we_global      = we_q;
  assign bus.wr_addr_global = addr_q;
  assign bus.wr_data_global = data_q;
`ifdef OFM_STORE_LANE_MASK_EN
  assign bus.wr_be_global   = be_q;
`endif
  assign busy_o             = busy_q;
  assign done_o             = done_q;

endmodule

// File: tb/tb_global_ofm_store_unit.sv
// Scoreboard bench for global_ofm_store_unit: expected writes are queued, a monitor checks each we_global.
// Also covers the OFM_STORE_LANE_MASK_EN build when that macro is defined.
module tb_global_ofm_store_unit;

  localparam int DATA_W     = 8;
  localparam int PACK       = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int WORD_W     = DATA_W * PACK;

  typedef struct {
    logic [31:0]       addr;
    logic [WORD_W-1:0] data;
    logic [PACK-1:0]   be;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] baseAddr = '0;
  logic [31:0] sizeOfm = '0;
  logic        busy, done;

  wr_t expQ[$];
  int  checks = 0;
  int  errors = 0;
  int  cycle = 0;
  int  weCount = 0;
  int  lastWeCycle = -10;
  int  accepted = 0;

  global_ofm_store_unit_if #(.DATA_W(DATA_W), .PACK(PACK)) bus();

  global_ofm_store_unit #(
    .DATA_W(DATA_W), .PACK(PACK), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start_i(start),
    .base_addr_OFM_i(baseAddr),
    .size_OFM_i(sizeOfm),
    .busy_o(busy),
    .done_o(done),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // monitor: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    wr_t e;
    cycle++;
    if (reset_n && bus.we_global) begin
      weCount++;
      lastWeCycle = cycle;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpectedWrite actual addr=%h data=%h required none", bus.wr_addr_global, bus.wr_data_global);
      end else begin
        e = expQ.pop_front();
`ifdef OFM_STORE_LANE_MASK_EN
        if (bus.wr_addr_global !== e.addr || bus.wr_data_global !== e.data || bus.wr_be_global !== e.be) begin
          errors++;
          $display("[TB] FAIL write actual addr=%h data=%h be=%h required addr=%h data=%h be=%h",
                   bus.wr_addr_global, bus.wr_data_global, bus.wr_be_global, e.addr, e.data, e.be);
        end
`else
        if (bus.wr_addr_global !== e.addr || bus.wr_data_global !== e.data) begin
          errors++;
          $display("[TB] FAIL write actual addr=%h data=%h required addr=%h data=%h",
                   bus.wr_addr_global, bus.wr_data_global, e.addr, e.data);
        end
`endif
      end
    end
  end

  task automatic checkOutput(input string name, input logic [WORD_W-1:0] actual, input logic [WORD_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic toPos();
    @(posedge clk);
    #1;
  endtask

  task automatic sampleNeg();
    @(negedge clk);
    #1;
  endtask

  task automatic pushExpected(input logic [31:0] base, input int size, input int first);
    int words;
    words = (size + PACK - 1) / PACK;
    for (int w = 0; w < words; w++) begin
      wr_t e;
      e.addr = base + 32'(w * 16);
      e.data = '0;
      e.be   = '0;
      for (int k = 0; k < PACK; k++) begin
        int idx;
        idx = w * PACK + k;
        if (idx < size) begin
          e.data[k*DATA_W +: DATA_W] = 8'(first + idx);
          e.be[k] = 1'b1;
        end
      end
      expQ.push_back(e);
    end
  endtask

  // call at posedge+1; returns at posedge+1 after the edge that took the start pulse
  task automatic startOp(input logic [31:0] base, input logic [31:0] size);
    start    = 1'b1;
    baseAddr = base;
    sizeOfm  = size;
    toPos();
    start = 1'b0;
  endtask

  // call at posedge+1; streams n elements with values first, first+1, ...
  task automatic applyStimulus(input int first, input int n);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 5000) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(first + i);
      @(negedge clk);
      if (bus.in_ready) begin
        i++;
        accepted++;
      end
      toPos();
      guard++;
    end
    bus.in_valid = 1'b0;
    if (i < n) begin
      checkOutput("streamTimeout", i, n);
    end
  endtask

  task automatic waitDone(input string name, input bit expectWe);
    int guard;
    guard = 0;
    sampleNeg();
    while (!done && guard < 3000) begin
      sampleNeg();
      guard++;
    end
    checkOutput({name, "_done"}, done, 1'b1);
    if (expectWe) begin
      checkOutput({name, "_doneAfterLastWe"}, cycle - lastWeCycle, 1);
    end
    checkOutput({name, "_queueEmpty"}, expQ.size(), 0);
    sampleNeg();
    checkOutput({name, "_donePulse"}, done, 1'b0);
    checkOutput({name, "_idle"}, busy, 1'b0);
    toPos();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0;
    int i;
    int guard;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.global_busy = 1'b0;

    // reset and idle
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    sampleNeg();
    checkOutput("rst_in_ready", bus.in_ready, 1'b0);
    checkOutput("rst_we", bus.we_global, 1'b0);
    checkOutput("rst_addr", bus.wr_addr_global, '0);
    checkOutput("rst_data", bus.wr_data_global, '0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
`ifdef OFM_STORE_LANE_MASK_EN
    checkOutput("rst_be", bus.wr_be_global, '0);
`endif
    w0 = weCount;
    repeat (5) sampleNeg();
    checkOutput("rst_noWrite", weCount, w0);
    toPos();

    // two full words
    expQ.push_back('{32'h0000_1000, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'hFFFF});
    expQ.push_back('{32'h0000_1010, 128'h1F1E1D1C_1B1A1918_17161514_13121110, 16'hFFFF});
    startOp(32'h1000, 32);
    sampleNeg();
    checkOutput("full_busy", busy, 1'b1);
    checkOutput("full_in_ready", bus.in_ready, 1'b1);
    toPos();
    applyStimulus(0, 32);
    waitDone("full", 1'b1);

    // partial last word, zero padded
    expQ.push_back('{32'h0000_2000, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'hFFFF});
    expQ.push_back('{32'h0000_2010, 128'h00000000_00000000_00000000_13121110, 16'h000F});
    startOp(32'h2000, 20);
    applyStimulus(0, 20);
    waitDone("partial", 1'b1);

    // backpressure: BRAM busy until the FIFO fills and input stalls
    pushExpected(32'h8000, 128, 0);
    bus.global_busy = 1'b1;
    accepted = 0;
    w0 = weCount;
    startOp(32'h8000, 128);
    fork
      applyStimulus(0, 128);
      begin
        repeat (75) @(negedge clk);
        #1;
        checkOutput("bp_in_ready", bus.in_ready, 1'b0);
        checkOutput("bp_accepted", accepted, 64);
        checkOutput("bp_noWriteWhileBusy", weCount - w0, 0);
        bus.global_busy = 1'b0;
      end
    join
    waitDone("bp", 1'b1);
    checkOutput("bp_writes", weCount - w0, 8);

    // zero size
    w0 = weCount;
    startOp(32'h4000, 0);
    sampleNeg();
    checkOutput("zero_done", done, 1'b1);
    checkOutput("zero_busy", busy, 1'b1);
    sampleNeg();
    checkOutput("zero_doneLow", done, 1'b0);
    checkOutput("zero_idle", busy, 1'b0);
    checkOutput("zero_noWrite", weCount, w0);
    toPos();

    // start during RUN is ignored
    pushExpected(32'h5000, 32, 8'h40);
    startOp(32'h5000, 32);
    applyStimulus(8'h40, 8);
    startOp(32'h9000, 0);
    sampleNeg();
    checkOutput("ign_busy", busy, 1'b1);
    checkOutput("ign_done", done, 1'b0);
    checkOutput("ign_in_ready", bus.in_ready, 1'b1);
    toPos();
    applyStimulus(8'h48, 24);
    waitDone("ign", 1'b1);

    // reset after three words have been written
    pushExpected(32'h6000, 128, 0);
    w0 = weCount;
    startOp(32'h6000, 128);
    i = 0;
    guard = 0;
    while (weCount - w0 < 3 && guard < 500) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      @(negedge clk);
      if (bus.in_ready) i++;
      toPos();
      guard++;
    end
    bus.in_valid = 1'b0;
    checkOutput("mid_threeWrites", weCount - w0, 3);
    reset_n = 1'b0;
    sampleNeg();
    checkOutput("mid_we", bus.we_global, 1'b0);
    checkOutput("mid_addr", bus.wr_addr_global, '0);
    checkOutput("mid_data", bus.wr_data_global, '0);
    checkOutput("mid_busy", busy, 1'b0);
    checkOutput("mid_in_ready", bus.in_ready, 1'b0);
    expQ.delete();
    toPos();
    toPos();
    reset_n = 1'b1;
    w0 = weCount;
    repeat (10) sampleNeg();
    checkOutput("mid_noWriteAfterReset", weCount, w0);
    toPos();
    pushExpected(32'h3000, 16, 8'hA0);
    startOp(32'h3000, 16);
    applyStimulus(8'hA0, 16);
    waitDone("restart", 1'b1);
    checkOutput("restart_writes", weCount - w0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
